// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by fetch and load/store, data wins; MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard.
// Latency: load/fetch ack 3 cycles after the request is sampled in IDLE, store 2; each memory wait cycle adds one.
// Backpressure: m_ready/m_rvalid hold the FSM in REQ/RESP; requesters are held off via stall_if/stall_d.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall_if,
    output logic                stall_d,
    output logic                grant_d,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_d_q, grant_d_d;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              arb;
    logic              pick_d;
    logic              force_fetch;
    logic              to_done;

    assign arb    = (state_q == IDLE) && (d_req || if_req);
    assign pick_d = d_req && !force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_fetch = if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; any fetch grant or idle fetch side clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb) begin
            if (!pick_d || !if_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign force_fetch = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d_d  = grant_d_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        to_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb) begin
                    state_d   = REQ;
                    grant_d_d = pick_d;
                    if (pick_d) begin
                        m_we_d    = d_we;
                        m_be_d    = d_be;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_be_d    = '1;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (m_ready) begin
                    if (m_we_q) begin
                        state_d = DONE;
                        to_done = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    state_d = DONE;
                    to_done = 1'b1;
                    if (grant_d_q) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        if_rdata_d = m_rdata;
                    end
                end
            end
            // DONE never arbitrates, so a req still high from the finished transaction is not re-granted.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if_ack_d = to_done && !grant_d_q;
        d_ack_d  = to_done && grant_d_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_d_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_d_q  <= grant_d_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_valid  = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign grant_d  = grant_d_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign stall_if = if_req && !if_ack_q;
    assign stall_d  = d_req && !d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus an ack scoreboard fed when requests are issued.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int BE_W         = DATA_W / 8;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              m_valid;
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              stall_if;
    logic              stall_d;
    logic              grant_d;
    logic              busy;

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_d(stall_d), .grant_d(grant_d), .busy(busy)
    );

    // Scoreboard: every ack must match the oldest outstanding expected completion.
    always @(negedge clk) begin
        if (resetn === 1'b1 && (if_ack === 1'b1 || d_ack === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got if_ack=%0b d_ack=%0b, expected no ack", if_ack, d_ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (d_ack !== mon_e.is_d || if_ack === d_ack) begin
                    errors++;
                    $display("FAIL sb_owner: got if_ack=%0b d_ack=%0b, expected d_ack=%0b only", if_ack, d_ack, mon_e.is_d);
                end else if (mon_e.chk && (mon_e.is_d ? d_rdata : if_rdata) !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h, expected %h", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_valid, m_we, m_be, m_addr, m_wdata, if_ack, d_ack, grant_d, busy, if_rdata, d_rdata, stall_if, stall_d} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got m_valid=%0b m_addr=%h busy=%0b grant_d=%0b if_rdata=%h d_rdata=%h, expected all 0",
                     m_valid, m_addr, busy, grant_d, if_rdata, d_rdata);
        end
        step();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%0b m_valid=%0b, expected 0 0", busy, m_valid);
        end
        step();
    endtask

    task automatic test_single_fetch;
        if_req  = 1'b1;
        if_addr = 32'h100;
        exp_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        for (int c = 0; c < 5; c++) begin
            m_ready  = (c == 1);
            m_rvalid = (c == 2);
            m_rdata  = (c == 2) ? 32'hDEADBEEF : 32'h0;
            if (c == 4) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== (c == 1)) begin
                errors++;
                $display("FAIL fetch_m_valid c%0d: got %0b, expected %0b", c, m_valid, (c == 1));
            end
            checks++;
            if (if_ack !== (c == 3)) begin
                errors++;
                $display("FAIL fetch_if_ack c%0d: got %0b, expected %0b", c, if_ack, (c == 3));
            end
            checks++;
            if (stall_if !== (c <= 2)) begin
                errors++;
                $display("FAIL fetch_stall_if c%0d: got %0b, expected %0b", c, stall_if, (c <= 2));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 3)) begin
                errors++;
                $display("FAIL fetch_busy c%0d: got %0b, expected %0b", c, busy, (c >= 1 && c <= 3));
            end
            if (c == 1) begin
                checks++;
                if (m_addr !== 32'h100 || m_we !== 1'b0 || m_be !== 4'hF || grant_d !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_fields: got addr=%h we=%0b be=%h grant_d=%0b, expected 100 0 f 0",
                             m_addr, m_we, m_be, grant_d);
                end
            end
            step();
        end
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_rdata_held: got %h, expected deadbeef", if_rdata);
        end
    endtask

    task automatic test_priority_store;
        if_req  = 1'b1;
        if_addr = 32'h300;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h200;
        d_wdata = 32'h12345678;
        exp_q.push_back('{1'b1, 1'b0, 32'h0});
        exp_q.push_back('{1'b0, 1'b1, 32'hCAFEF00D});
        for (int c = 0; c < 8; c++) begin
            m_ready  = (c == 1 || c == 4);
            m_rvalid = (c == 5);
            m_rdata  = (c == 5) ? 32'hCAFEF00D : 32'h0;
            if (c == 3) d_req = 1'b0;
            if (c == 7) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== (c == 1 || c == 4)) begin
                errors++;
                $display("FAIL prio_m_valid c%0d: got %0b, expected %0b", c, m_valid, (c == 1 || c == 4));
            end
            checks++;
            if (d_ack !== (c == 2) || if_ack !== (c == 6)) begin
                errors++;
                $display("FAIL prio_acks c%0d: got d_ack=%0b if_ack=%0b, expected %0b %0b", c, d_ack, if_ack, (c == 2), (c == 6));
            end
            checks++;
            if (stall_d !== (c <= 1) || stall_if !== (c <= 5)) begin
                errors++;
                $display("FAIL prio_stalls c%0d: got stall_d=%0b stall_if=%0b, expected %0b %0b", c, stall_d, stall_if, (c <= 1), (c <= 5));
            end
            checks++;
            if (busy !== (c != 0 && c != 3 && c != 7)) begin
                errors++;
                $display("FAIL prio_busy c%0d: got %0b, expected %0b", c, busy, (c != 0 && c != 3 && c != 7));
            end
            if (c == 1) begin
                checks++;
                if (grant_d !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h200 || m_wdata !== 32'h12345678 || m_be !== 4'hF) begin
                    errors++;
                    $display("FAIL prio_store_fields: got grant_d=%0b we=%0b addr=%h wdata=%h be=%h, expected 1 1 200 12345678 f",
                             grant_d, m_we, m_addr, m_wdata, m_be);
                end
            end
            if (c == 4) begin
                checks++;
                if (grant_d !== 1'b0 || m_we !== 1'b0 || m_addr !== 32'h300 || m_be !== 4'hF) begin
                    errors++;
                    $display("FAIL prio_fetch_fields: got grant_d=%0b we=%0b addr=%h be=%h, expected 0 0 300 f",
                             grant_d, m_we, m_addr, m_be);
                end
            end
            step();
        end
    endtask

    task automatic test_wait_states;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'h3;
        d_addr = 32'h400;
        exp_q.push_back('{1'b1, 1'b1, 32'hA5A50F0F});
        for (int c = 0; c < 10; c++) begin
            m_ready  = (c == 4);
            m_rvalid = (c == 2 || c == 7);
            m_rdata  = (c == 2) ? 32'hBAD0BAD0 : ((c == 7) ? 32'hA5A50F0F : 32'h0);
            if (c == 9) d_req = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== (c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL wait_m_valid c%0d: got %0b, expected %0b", c, m_valid, (c >= 1 && c <= 4));
            end
            checks++;
            if (d_ack !== (c == 8)) begin
                errors++;
                $display("FAIL wait_d_ack c%0d: got %0b, expected %0b", c, d_ack, (c == 8));
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (m_addr !== 32'h400 || m_be !== 4'h3 || m_we !== 1'b0 || grant_d !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_fields_stable c%0d: got addr=%h be=%h we=%0b grant_d=%0b, expected 400 3 0 1",
                             c, m_addr, m_be, m_we, grant_d);
                end
            end
            if (c == 5) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL wait_stray_rvalid: got d_rdata=%h, expected 0", d_rdata);
                end
            end
            if (c == 8) begin
                checks++;
                if (if_rdata !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL wait_if_rdata_untouched: got %h, expected cafef00d", if_rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_starvation;
        int acks;
        int fetch_acks;
        int exp_fetch;
        acks       = 0;
        fetch_acks = 0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h700;
        d_wdata = 32'h77777777;
        if_req  = 1'b1;
        if_addr = 32'h800;
        m_ready  = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h600DF00D;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_fetch = 2;
        for (int i = 0; i < 10; i++) exp_q.push_back('{(i % 5) != 4, (i % 5) == 4, 32'h600DF00D});
`else
        exp_fetch = 0;
        for (int i = 0; i < 10; i++) exp_q.push_back('{1'b1, 1'b0, 32'h0});
`endif
        for (int c = 0; c < 120 && acks < 10; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1 || if_ack === 1'b1) acks++;
            if (if_ack === 1'b1) fetch_acks++;
            step();
        end
        d_req    = 1'b0;
        if_req   = 1'b0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        checks++;
        if (acks != 10) begin
            errors++;
            $display("FAIL starve_timeout: got %0d acks, expected 10", acks);
        end
        checks++;
        if (fetch_acks != exp_fetch) begin
            errors++;
            $display("FAIL starve_fetch_grants: got %0d, expected %0d", fetch_acks, exp_fetch);
        end
        step();
    endtask

    task automatic test_reset_midflight;
        if_req  = 1'b1;
        if_addr = 32'h500;
        exp_q.push_back('{1'b0, 1'b1, 32'h11111111});
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_reach_resp: got busy=%0b m_valid=%0b, expected 1 0", busy, m_valid);
        end
        #2;
        resetn = 1'b0;
        if_req = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({m_valid, m_we, m_be, m_addr, m_wdata, if_ack, d_ack, grant_d, busy, if_rdata, d_rdata, stall_if, stall_d} !== '0) begin
            errors++;
            $display("FAIL rst_async_clear: got m_valid=%0b m_addr=%h busy=%0b if_rdata=%h d_rdata=%h, expected all 0",
                     m_valid, m_addr, busy, if_rdata, d_rdata);
        end
        step();
        resetn   = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h22222222;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (if_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rst_late_rvalid c%0d: got if_ack=%0b d_ack=%0b busy=%0b if_rdata=%h, expected 0 0 0 0",
                         c, if_ack, d_ack, busy, if_rdata);
            end
            step();
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
        end
    endtask

    initial begin
        resetn   = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = '0;
        d_addr   = '0;
        d_wdata  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        test_reset();
        test_single_fetch();
        test_priority_store();
        test_wait_states();
        test_starvation();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_outstanding: got %0d expected acks never seen, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
